// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle shared by the team's master and the register-file completer.
interface apb_slave_regfile_if;
    logic [1:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a DEPTH x 32-bit register file, programmable wait states
// and a one-cycle registered pready pulse per completed transfer.
module apb_slave_regfile #(
    parameter logic [1:0] SLAVE_ID    = 2'b01,
    parameter int         DEPTH       = 16,
    parameter int         WAIT_CYCLES = 1
) (
    input  logic               pclk,
    input  logic               prst,
    apb_slave_regfile_if.slave apb,
    output logic [15:0]        xfer_count
);
    localparam int         ADDR_W  = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t              state_q;
    logic [3:0]          wcnt_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic                pready_q;
    logic [31:0]         prdata_q;
    logic                pslverr_q;
    logic [15:0]         xfer_count_q;
    logic [31:0]         mem_q [DEPTH];

    logic                sel;
    logic                req;
    logic [ADDR_W-1:0]   idx_in;
    logic                err_in;
    logic                go_resp;
    logic                acc_wr_d;
    logic [ADDR_W-1:0]   acc_idx_d;
    logic [31:0]         acc_wdata_d;
    logic                acc_err_d;

    assign sel     = (apb.pselx == SLAVE_ID);
    assign req     = sel & apb.penable;
    assign idx_in  = apb.paddr[ADDR_W+1:2];
    assign err_in  = (apb.paddr[1:0] != 2'b00) | (apb.paddr[31:ADDR_W+2] != '0);
    assign go_resp = req & (((state_q == IDLE) & NO_WAIT) |
                            ((state_q == WAIT) & (wcnt_q == 4'd1)));

    // With no wait states the access completes on the sampling edge itself,
    // so the live bus must be used instead of the (not yet loaded) latches.
    always_comb begin
        if (state_q == IDLE) begin
            acc_wr_d    = apb.pwrite;
            acc_idx_d   = idx_in;
            acc_wdata_d = apb.pwdata;
            acc_err_d   = err_in;
        end else begin
            acc_wr_d    = wr_q;
            acc_idx_d   = idx_q;
            acc_wdata_d = wdata_q;
            acc_err_d   = err_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= IDLE;
            wcnt_q       <= 4'd0;
            pready_q     <= 1'b0;
            prdata_q     <= 32'd0;
            pslverr_q    <= 1'b0;
            xfer_count_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            pready_q  <= 1'b0;
            prdata_q  <= 32'd0;
            pslverr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q    <= apb.pwrite;
                        idx_q   <= idx_in;
                        wdata_q <= apb.pwdata;
                        err_q   <= err_in;
                        wcnt_q  <= WAIT_LD;
                        state_q <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                        if (wcnt_q == 4'd1) begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: state_q <= HOLD;
                HOLD: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (go_resp) begin
                pready_q     <= 1'b1;
                xfer_count_q <= xfer_count_q + 16'd1;
                if (acc_err_d) begin
                    pslverr_q <= 1'b1;
                end else if (acc_wr_d) begin
                    mem_q[acc_idx_d] <= acc_wdata_d;
                end else begin
                    prdata_q <= mem_q[acc_idx_d];
                end
            end
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
    assign xfer_count  = xfer_count_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: three completers (wait states 1, 0, 3) on one APB bus, checked
// against a scoreboard of expected responses and a register-file model.
module tb_apb_slave_regfile;
    logic        pclk;
    logic        prst;
    logic [1:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [15:0] cnt1, cnt0, cnt3;
    logic        bus_rdy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        wr;
        int          lat;
        logic [31:0] rd;
        logic        err;
        int          pulses;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m1[16];

    apb_slave_regfile_if if1 ();
    apb_slave_regfile_if if0 ();
    apb_slave_regfile_if if3 ();

    assign if1.pselx = pselx;  assign if1.penable = penable;  assign if1.pwrite = pwrite;
    assign if1.paddr = paddr;  assign if1.pwdata  = pwdata;
    assign if0.pselx = pselx;  assign if0.penable = penable;  assign if0.pwrite = pwrite;
    assign if0.paddr = paddr;  assign if0.pwdata  = pwdata;
    assign if3.pselx = pselx;  assign if3.penable = penable;  assign if3.pwrite = pwrite;
    assign if3.paddr = paddr;  assign if3.pwdata  = pwdata;
    assign bus_rdy = if1.pready | if0.pready | if3.pready;

    apb_slave_regfile #(.SLAVE_ID(2'b01), .DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
        .pclk(pclk), .prst(prst), .apb(if1), .xfer_count(cnt1));
    apb_slave_regfile #(.SLAVE_ID(2'b10), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .prst(prst), .apb(if0), .xfer_count(cnt0));
    apb_slave_regfile #(.SLAVE_ID(2'b11), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .prst(prst), .apb(if3), .xfer_count(cnt3));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic bus_idle();
        pselx = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        prst = 1'b1;
        bus_idle();
        repeat (2) @(posedge pclk);
        #1 prst = 1'b0;
        for (int i = 0; i < 16; i++) m1[i] = 32'd0;
    endtask

    task automatic snoop(input logic [1:0] s, output logic hit, output logic [31:0] d,
                         output logic e, output logic other);
        case (s)
            2'b01:   begin hit = if1.pready; d = if1.prdata; e = if1.pslverr; other = if0.pready | if3.pready; end
            2'b10:   begin hit = if0.pready; d = if0.prdata; e = if0.pslverr; other = if1.pready | if3.pready; end
            2'b11:   begin hit = if3.pready; d = if3.prdata; e = if3.pslverr; other = if1.pready | if0.pready; end
            default: begin hit = 1'b0; d = 32'd0; e = 1'b0; other = bus_rdy; end
        endcase
    endtask

    // One master transfer; returns what the addressed completer did.
    task automatic apb_xfer(input logic [1:0] s, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int hold, output int lat,
                            output logic [31:0] rd, output logic er, output int pulses,
                            output int stray);
        int c;
        bit seen;
        logic hit, e, other;
        logic [31:0] d;
        lat = 0; rd = 32'd0; er = 1'b0; pulses = 0; stray = 0; seen = 0; c = 0;
        @(posedge pclk); #1;
        pselx = s; penable = 1'b1; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk);
        while (!seen && c < 12) begin
            @(negedge pclk);
            c++;
            snoop(s, hit, d, e, other);
            if (hit) begin pulses++; seen = 1; lat = c; rd = d; er = e; end
            if (other) stray++;
        end
        if (seen) begin
            @(posedge pclk);
            for (int h = 0; h < hold; h++) begin
                @(negedge pclk);
                snoop(s, hit, d, e, other);
                if (hit) pulses++;
                if (other) stray++;
                @(posedge pclk);
            end
        end
        #1 bus_idle();
        repeat (2) begin
            @(negedge pclk);
            snoop(s, hit, d, e, other);
            if (hit) pulses++;
            if (other) stray++;
        end
    endtask

    // Push the expected response of a slave-01 transfer and update its model.
    task automatic expect_w1(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        logic bad;
        bad = (addr[1:0] != 2'b00) || (addr[31:6] != 26'd0);
        e.wr = wr; e.lat = 2; e.err = bad; e.pulses = 1;
        e.rd = (bad || wr) ? 32'd0 : m1[addr[5:2]];
        if (!bad && wr) m1[addr[5:2]] = wd;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [49:0] st[3];
        prst = 1'b1;
        bus_idle();
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        for (int i = 0; i < 16; i++) m1[i] = 32'd0;
        @(negedge pclk);
        st[0] = {if1.pready, if1.pslverr, if1.prdata, cnt1};
        st[1] = {if0.pready, if0.pslverr, if0.prdata, cnt0};
        st[2] = {if3.pready, if3.pslverr, if3.prdata, cnt3};
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (st[i] !== 50'd0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got %h, want 0", i, st[i]);
            end
        end
    endtask

    task automatic test_write_read();
        logic        wr_t[3]   = '{1'b1, 1'b0, 1'b0};
        logic [31:0] addr_t[3] = '{32'h08, 32'h08, 32'h0C};
        logic [31:0] wd_t[3]   = '{32'hDEADBEEF, 32'h0, 32'h0};
        logic [31:0] rd_t[3]   = '{32'h0, 32'hDEADBEEF, 32'h0};
        int lat, pulses, stray;
        logic [31:0] rd;
        logic er;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            expect_w1(wr_t[i], addr_t[i], wd_t[i]);
            apb_xfer(2'b01, wr_t[i], addr_t[i], wd_t[i], 0, lat, rd, er, pulses, stray);
            e = sb.pop_front();
            vectors++;
            if (lat !== e.lat) begin miscompares++; $display("FAIL wr_rd[%0d] latency: got %0d, want %0d", i, lat, e.lat); end
            vectors++;
            if (er !== e.err) begin miscompares++; $display("FAIL wr_rd[%0d] pslverr: got %b, want %b", i, er, e.err); end
            if (!e.wr) begin
                vectors++;
                if (rd !== rd_t[i] || rd !== e.rd) begin
                    miscompares++; $display("FAIL wr_rd[%0d] prdata: got %h, want %h", i, rd, rd_t[i]);
                end
            end
            vectors++;
            if (pulses !== e.pulses || stray !== 0) begin
                miscompares++; $display("FAIL wr_rd[%0d] pulses: got %0d (stray %0d), want 1 (stray 0)", i, pulses, stray);
            end
            if (i == 0) begin
                vectors++;
                if (cnt1 !== 16'd1) begin miscompares++; $display("FAIL wr_rd xfer_count_after_write: got %0d, want 1", cnt1); end
            end
        end
        vectors++;
        if (cnt1 !== 16'd3) begin miscompares++; $display("FAIL wr_rd xfer_count: got %0d, want 3", cnt1); end
    endtask

    task automatic test_errors();
        logic        wr_t[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] addr_t[4] = '{32'h05, 32'h40, 32'h04, 32'h08};
        logic [31:0] wd_t[4]   = '{32'h12345678, 32'h0, 32'h0, 32'h0};
        logic        err_t[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] rd_t[4]   = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
        int lat, pulses, stray;
        logic [31:0] rd;
        logic er;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            expect_w1(wr_t[i], addr_t[i], wd_t[i]);
            apb_xfer(2'b01, wr_t[i], addr_t[i], wd_t[i], 0, lat, rd, er, pulses, stray);
            e = sb.pop_front();
            vectors++;
            if (er !== err_t[i] || er !== e.err) begin
                miscompares++; $display("FAIL err[%0d] pslverr: got %b, want %b", i, er, err_t[i]);
            end
            vectors++;
            if (lat !== e.lat || pulses !== e.pulses) begin
                miscompares++; $display("FAIL err[%0d] timing: got lat %0d pulses %0d, want lat %0d pulses 1", i, lat, pulses, e.lat);
            end
            if (!e.wr) begin
                vectors++;
                if (rd !== rd_t[i] || rd !== e.rd) begin
                    miscompares++; $display("FAIL err[%0d] prdata: got %h, want %h", i, rd, rd_t[i]);
                end
            end
        end
        vectors++;
        if (cnt1 !== 16'd7) begin miscompares++; $display("FAIL err xfer_count: got %0d, want 7", cnt1); end
    endtask

    task automatic test_other_slave();
        logic [1:0]  sel_t[6]  = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
        logic        wr_t[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] addr_t[6] = '{32'h08, 32'h08, 32'h08, 32'h08, 32'h08, 32'h08};
        logic [31:0] wd_t[6]   = '{32'h11112222, 32'h0, 32'h33334444, 32'h0, 32'h77778888, 32'h0};
        int          lat_t[6]  = '{1, 1, 4, 4, 0, 2};
        logic [31:0] rd_t[6]   = '{32'h0, 32'h11112222, 32'h0, 32'h33334444, 32'h0, 32'hDEADBEEF};
        int lat, pulses, stray;
        logic [31:0] rd;
        logic er;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            if (sel_t[i] == 2'b01) expect_w1(wr_t[i], addr_t[i], wd_t[i]);
            else sb.push_back('{wr: wr_t[i], lat: lat_t[i], rd: rd_t[i], err: 1'b0,
                               pulses: (sel_t[i] == 2'b00) ? 0 : 1});
            apb_xfer(sel_t[i], wr_t[i], addr_t[i], wd_t[i], 0, lat, rd, er, pulses, stray);
            e = sb.pop_front();
            vectors++;
            if (lat !== lat_t[i] || lat !== e.lat) begin
                miscompares++; $display("FAIL other[%0d] latency: got %0d, want %0d", i, lat, lat_t[i]);
            end
            vectors++;
            if (pulses !== e.pulses || stray !== 0 || er !== e.err) begin
                miscompares++; $display("FAIL other[%0d] response: got pulses %0d stray %0d err %b, want %0d/0/%b", i, pulses, stray, er, e.pulses, e.err);
            end
            if (!e.wr) begin
                vectors++;
                if (rd !== e.rd) begin miscompares++; $display("FAIL other[%0d] prdata: got %h, want %h", i, rd, e.rd); end
            end
            if (i == 4) begin
                vectors++;
                if (cnt1 !== 16'd7) begin miscompares++; $display("FAIL other xfer_count_unselected: got %0d, want 7", cnt1); end
            end
        end
        vectors++;
        if (cnt0 !== 16'd2 || cnt3 !== 16'd2) begin
            miscompares++; $display("FAIL other xfer_counts: got %0d/%0d, want 2/2", cnt0, cnt3);
        end
    endtask

    task automatic test_abort();
        int seen;
        int lat, pulses, stray;
        logic [31:0] rd;
        logic er;
        exp_t e;
        @(posedge pclk); #1;
        pselx = 2'b11; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h55AA55AA;
        repeat (2) @(posedge pclk);
        #1 bus_idle();
        seen = 0;
        repeat (6) begin
            @(negedge pclk);
            if (bus_rdy) seen++;
        end
        vectors++;
        if (seen !== 0 || cnt3 !== 16'd2) begin
            miscompares++; $display("FAIL abort no_response: got %0d pready cycles count %0d, want 0 and 2", seen, cnt3);
        end
        sb.push_back('{wr: 1'b0, lat: 4, rd: 32'h0, err: 1'b0, pulses: 1});
        apb_xfer(2'b11, 1'b0, 32'h0C, 32'h0, 0, lat, rd, er, pulses, stray);
        e = sb.pop_front();
        vectors++;
        if (rd !== e.rd || lat !== e.lat || pulses !== e.pulses) begin
            miscompares++; $display("FAIL abort readback: got %h lat %0d, want %h lat %0d", rd, lat, e.rd, e.lat);
        end
        vectors++;
        if (cnt3 !== 16'd3) begin miscompares++; $display("FAIL abort xfer_count: got %0d, want 3", cnt3); end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        int lat, pulses, stray;
        logic [31:0] rd;
        logic er;
        logic [31:0] addr_t[2] = '{32'h10, 32'h08};
        exp_t e;
        @(posedge pclk); #1;
        pselx = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFEF00D;
        @(posedge pclk); #1 prst = 1'b1;
        @(posedge pclk); #1 prst = 1'b0;
        bus_idle();
        for (int i = 0; i < 16; i++) m1[i] = 32'd0;
        seen = 0;
        repeat (4) begin
            @(negedge pclk);
            if (bus_rdy) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL prst no_pready: got %0d cycles, want 0", seen); end
        vectors++;
        if (cnt1 !== 16'd0) begin miscompares++; $display("FAIL prst xfer_count: got %0d, want 0", cnt1); end
        for (int i = 0; i < 2; i++) begin
            expect_w1(1'b0, addr_t[i], 32'h0);
            apb_xfer(2'b01, 1'b0, addr_t[i], 32'h0, 0, lat, rd, er, pulses, stray);
            e = sb.pop_front();
            vectors++;
            if (rd !== 32'h0 || rd !== e.rd || lat !== e.lat || er !== e.err) begin
                miscompares++; $display("FAIL prst readback[%0d]: got %h lat %0d, want 0 lat 2", i, rd, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx_t[20] = '{0, 0, 1, 10, 2, 11, 3, 3, 4, 12, 5, 13, 6, 6, 7, 14, 8, 15, 9, 9};
        int lat, pulses, stray;
        logic [31:0] rd, wd, addr;
        logic er, wr;
        exp_t e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr   = (i % 2 == 0);
            addr = 32'(idx_t[i]) << 2;
            wd   = wr ? $urandom : 32'h0;
            expect_w1(wr, addr, wd);
            apb_xfer(2'b01, wr, addr, wd, 1, lat, rd, er, pulses, stray);
            e = sb.pop_front();
            vectors++;
            if (pulses !== e.pulses || lat !== e.lat || stray !== 0 || er !== e.err) begin
                miscompares++; $display("FAIL b2b[%0d] handshake: got pulses %0d lat %0d err %b, want 1/%0d/%b", i, pulses, lat, er, e.lat, e.err);
            end
            if (!e.wr) begin
                vectors++;
                if (rd !== e.rd) begin miscompares++; $display("FAIL b2b[%0d] prdata: got %h, want %h", i, rd, e.rd); end
            end
        end
        vectors++;
        if (cnt1 !== 16'd20) begin miscompares++; $display("FAIL b2b xfer_count: got %0d, want 20", cnt1); end
    endtask

    initial begin
        prst = 1'b1;
        bus_idle();
        test_reset();
        test_write_read();
        test_errors();
        test_other_slave();
        test_abort();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
